uart_tx_engine: RTL and testbench

//  Transmit side of the UART interface. Pops {parity, byte} entries from the FIFO buffer one per frame.

---
 rtl/uart_tx_engine.sv | 103 ++++++++++
 tb/tb_uart_tx_engine.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_engine.sv
// UART transmit engine: pops {parity, byte} from the FIFO and sends start, 8 data bits LSB first, stored parity, stop.
// Define UART_TX_TWO_STOP_EN to send two stop bits (12 bit periods per frame instead of 11).
module uart_tx_engine #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TX_EN,
  input  logic       BUF_AVAIL,
  input  logic [7:0] BUF_DATA,
  input  logic       BUF_PARITY,
  output logic       BUF_READ,
  output logic       TX,
  output logic       BUSY,
  output logic       FRAME_DONE
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
`ifdef UART_TX_TWO_STOP_EN
  localparam logic [2:0] STOP_LAST = 3'd1;
`else
  localparam logic [2:0] STOP_LAST = 3'd0;
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    WAIT   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_t;

  state_t          state, next_state;
  logic [BW-1:0]   baud_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic            par;
  logic            baud_last;
  logic            in_bit;
  logic            tx_next;

  always_comb begin
    next_state = state;
    baud_last  = (baud_cnt == BAUD_MAX);
    in_bit     = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);
    tx_next    = 1'b1;
    case (state)
      IDLE:   if (TX_EN && BUF_AVAIL) next_state = READ;
      READ:   next_state = WAIT;
      WAIT:   next_state = START;
      START: begin
        tx_next = 1'b0;
        if (baud_last) next_state = DATA;
      end
      DATA: begin
        tx_next = shift[0];
        if (baud_last && bit_cnt == 3'd7) next_state = PARITY;
      end
      PARITY: begin
        tx_next = par;
        if (baud_last) next_state = STOP;
      end
      STOP:   if (baud_last && bit_cnt == STOP_LAST) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered from the current state, so the line trails the FSM by one cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      par        <= 1'b0;
      TX         <= 1'b1;
      BUF_READ   <= 1'b0;
      BUSY       <= 1'b0;
      FRAME_DONE <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state != state || !in_bit || baud_last) baud_cnt <= '0;
      else baud_cnt <= baud_cnt + 1'b1;
      if (next_state != state) bit_cnt <= '0;
      else if (baud_last && (state == DATA || state == STOP)) bit_cnt <= bit_cnt + 1'b1;
      if (state == WAIT) begin
        shift <= BUF_DATA;
        par   <= BUF_PARITY;
      end else if (state == DATA && baud_last) begin
        shift <= {1'b0, shift[7:1]};
      end
      TX         <= tx_next;
      BUF_READ   <= (state == READ);
      BUSY       <= (state != IDLE);
      // BUSY still high while the FSM already sits in IDLE marks the cycle right after a stop bit.
      FRAME_DONE <= (state == IDLE) && BUSY;
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine at CLKS_PER_BIT=4 with a small FIFO model feeding BUF_* inputs.
module tb_uart_tx_engine;

  localparam int CPB = 4;
`ifdef UART_TX_TWO_STOP_EN
  localparam int FRAME_CYC = 12 * CPB;
`else
  localparam int FRAME_CYC = 11 * CPB;
`endif

  logic       clk;
  logic       rst;
  logic       tx_en;
  logic       buf_avail;
  logic [7:0] buf_data;
  logic       buf_parity;
  logic       buf_read;
  logic       tx;
  logic       busy;
  logic       frame_done;

  logic [8:0] fifo_q[$];
  int         rd_count = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  int         idle_v;
  int         lat;
  int         r0;
  int         errs;
  logic       got;

  uart_tx_engine #(.CLKS_PER_BIT(CPB)) dut (
    .CLK(clk),
    .RST(rst),
    .TX_EN(tx_en),
    .BUF_AVAIL(buf_avail),
    .BUF_DATA(buf_data),
    .BUF_PARITY(buf_parity),
    .BUF_READ(buf_read),
    .TX(tx),
    .BUSY(busy),
    .FRAME_DONE(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    buf_avail = (fifo_q.size() != 0);
    if (fifo_q.size() != 0) {buf_parity, buf_data} = fifo_q[0];
    else {buf_parity, buf_data} = 9'h0EE;
  endtask

  task automatic push(input logic [7:0] d, input logic p);
    fifo_q.push_back({p, d});
    refresh();
  endtask

  // FIFO model: pops on the edge that samples BUF_READ, head visible until then.
  always @(posedge clk) begin
    if (buf_read === 1'b1) begin
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      rd_count++;
    end
    #1 refresh();
  end

  function automatic logic exp_bit(input logic [7:0] d, input logic p, input int slot);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return d[slot-1];
    if (slot == 9) return p;
    return 1'b1;
  endfunction

  task automatic run_frame(input logic [7:0] d, input logic p, input string tag, output int idle);
    int   ferrs;
    int   fd_at;
    int   fd_cnt;
    logic fell;
    idle = 0;
    fell = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        fell = 1'b1;
        break;
      end
      idle++;
    end
    check({tag, "_start"}, 32'(fell), 32'd1);
    if (!fell) return;
    ferrs  = 0;
    fd_at  = -1;
    fd_cnt = 0;
    for (int c = 0; c <= FRAME_CYC + 1; c++) begin
      if (c > 0) @(negedge clk);
      if (c < FRAME_CYC) begin
        if (tx !== exp_bit(d, p, c / CPB)) ferrs++;
      end else if (tx !== 1'b1) begin
        ferrs++;
      end
      if (frame_done === 1'b1) begin
        fd_cnt++;
        if (fd_at < 0) fd_at = c;
      end
    end
    check({tag, "_bits"}, 32'(ferrs), 32'd0);
    check({tag, "_done_at"}, 32'(fd_at), 32'(FRAME_CYC));
    check({tag, "_done_cnt"}, 32'(fd_cnt), 32'd1);
  endtask

  initial begin
    rst   = 1'b1;
    tx_en = 1'b1;
    refresh();

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_hold", 32'({tx, busy, buf_read, frame_done}), 32'h8);
    end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("reset_release", 32'({tx, busy, buf_read, frame_done}), 32'h8);
    end

    // Single frame 0xA5, parity 0, with read and start-bit latency
    r0  = rd_count;
    lat = -1;
    push(8'hA5, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (buf_read === 1'b1) begin
        lat = i;
        break;
      end
    end
    check("lat_read", 32'(lat), 32'd2);
    run_frame(8'hA5, 1'b0, "a5", idle_v);
    check("lat_tx", 32'(idle_v), 32'd1);
    check("a5_pops", 32'(rd_count - r0), 32'd1);

    // Three queued entries back to back
    r0 = rd_count;
    push(8'h00, 1'b0);
    push(8'hFF, 1'b0);
    push(8'h3C, 1'b1);
    run_frame(8'h00, 1'b0, "b2b0", idle_v);
    run_frame(8'hFF, 1'b0, "b2b1", idle_v);
    check("gap1", 32'(idle_v + 2), 32'd3);
    run_frame(8'h3C, 1'b1, "b2b2", idle_v);
    check("gap2", 32'(idle_v + 2), 32'd3);
    repeat (20) @(negedge clk);
    check("b2b_pops", 32'(rd_count - r0), 32'd3);

    // TX_EN low holds IDLE even with data waiting
    tx_en = 1'b0;
    push(8'h5A, 1'b1);
    r0   = rd_count;
    errs = 0;
    repeat (100) begin
      @(negedge clk);
      if (buf_read !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) errs++;
    end
    check("en_hold", 32'(errs + rd_count - r0), 32'd0);
    tx_en = 1'b1;
    lat   = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (buf_read === 1'b1) begin
        lat = i;
        break;
      end
    end
    check("en_lat", 32'(lat), 32'd2);
    fork
      run_frame(8'h5A, 1'b1, "en_drop", idle_v);
      begin
        repeat (20) @(negedge clk);
        tx_en = 1'b0;
      end
    join
    tx_en = 1'b1;

    // Reset during data bit 3 discards the popped entry
    r0 = rd_count;
    push(8'h81, 1'b0);
    push(8'h42, 1'b1);
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        got = 1'b1;
        break;
      end
    end
    check("rst_frame_start", 32'(got), 32'd1);
    repeat (17) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid", 32'({tx, busy, buf_read, frame_done}), 32'h8);
    rst = 1'b0;
    run_frame(8'h42, 1'b1, "after_rst", idle_v);
    check("rst_pops", 32'(rd_count - r0), 32'd2);

    // 0x01 with parity 1: stop period length depends on build
    push(8'h01, 1'b1);
    run_frame(8'h01, 1'b1, "stop_len", idle_v);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
